sram_cmd_q: RTL and testbench
=============================

SRAM_CMD_Q -- requirements
Module: sram_cmd_q

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning width of write data and read data.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width, giving a memory of 2**ADDR_W words.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries, a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, width 1, meaning a command is offered.
REQ-007 The block SHALL have port cmd_ready, output, width 1, meaning a command can be accepted this cycle.
REQ-008 The block SHALL have port cmd_we, input, width 1, meaning 1 = write, 0 = read.
REQ-009 The block SHALL have port cmd_addr, input, width ADDR_W, meaning the word address.
REQ-010 The block SHALL have port cmd_wdata, input, width DATA_W, meaning write data, ignored for reads.
REQ-011 The block SHALL have port rsp_valid, output, width 1, meaning read data is presented.
REQ-012 The block SHALL have port rsp_ready, input, width 1, meaning the consumer takes the response.
REQ-013 The block SHALL have port rsp_data, output, width DATA_W, meaning read data.
REQ-014 The block SHALL have port rsp_addr, output, width ADDR_W, meaning the address of the read being returned.
REQ-015 The block SHALL have port level, output, width $clog2(DEPTH+1), meaning the current FIFO occupancy.
REQ-016 The block SHALL have port init_done, output, width 1, meaning the memory clear has completed.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; {cmd_we, cmd_addr, cmd_wdata} are pushed into the FIFO.
REQ-018 cmd_ready SHALL equal (state==RUN) && (level < DEPTH), with no full-cycle pop-through: a full FIFO deasserts ready even if a pop occurs that cycle.
REQ-019 The FSM SHALL have states INIT and RUN; it SHALL enter INIT on reset.
REQ-020 In INIT, an address counter SHALL write 0 to mem[0] through mem[2**ADDR_W-1], one word per edge; on the edge that writes the last word the FSM SHALL move to RUN.
REQ-021 init_done SHALL equal (state==RUN).
REQ-022 In RUN, the FIFO head SHALL issue at most one memory access per edge, strictly in acceptance order.
REQ-023 A head write SHALL issue whenever the FIFO is non-empty; mem[addr] SHALL update at that edge and the entry SHALL pop.
REQ-024 A head read SHALL issue only if !rsp_valid || rsp_ready; at that edge rsp_data <= mem[addr], rsp_addr <= addr, rsp_valid <= 1, and the entry SHALL pop.
REQ-025 A blocked head read SHALL stall all younger entries, writes included, and rsp_data/rsp_addr SHALL hold stable while rsp_valid && !rsp_ready.
REQ-026 rsp_valid SHALL clear on an edge with rsp_ready=1 and no new read issuing; with rsp_ready=1 and a new read issuing, the response SHALL be replaced back-to-back.
REQ-027 Latency: a read accepted at edge E into an empty FIFO, with the response slot free, SHALL present rsp_valid after edge E+1.
REQ-028 A read SHALL return the value of the most recent earlier-accepted write to the same address; the FIFO is in order and there is no forwarding path.
REQ-029 On a simultaneous push and pop, level SHALL be unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 level SHALL equal the number of accepted, unissued commands.

Reset
REQ-031 While rst_n=0, regardless of clock: state=INIT, init counter=0, FIFO empty, level=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0, init_done=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued commands and any pending response, then restart the full INIT clear.
REQ-033 Memory contents SHALL NOT be cleared by rst_n itself; only the INIT sweep clears them.

Verification
REQ-034 Init: release reset, hold cmd_valid=0, count edges -> init_done and cmd_ready rise after exactly 16 edges (ADDR_W=4); then read addr 9 -> rsp_data=0, rsp_addr=9.
REQ-035 Basic: write addr 3=55, write addr 5=77, read 3, read 5 with rsp_ready=1 -> responses 55 at addr 3, then 77 at addr 5, in order, the first one edge after acceptance plus one.
REQ-036 Backpressure: rsp_ready=0; write 3=55; read 3; read 5; write 3=99 -> rsp 55 held stable, level=2 (read 5 and write 99 queued); raise rsp_ready -> rsp 77, then write lands; a later read 3 -> 99.
REQ-037 Full: rsp_ready=0, response slot occupied, push 4 reads -> level=4, cmd_ready=0 while cmd_valid=1, no 5th accept; release rsp_ready -> drain with level 4,3,2,1,0.
REQ-038 Reset mid-operation: with level=3 and rsp_valid=1, pulse rst_n low between edges -> rsp_valid=0 and level=0 immediately; 16-edge INIT reruns; read addr 3 -> 0.
REQ-039 Parameter sweep: DATA_W=16, ADDR_W=6, DEPTH=8 -> write 63=0xBEEF, read 63 -> 0xBEEF; INIT takes 64 edges.

Source files
------------

// File: rtl/sram_cmd_q.sv
// In-order command FIFO in front of a single-port SRAM.
// The memory is swept to zero after every reset before commands are accepted.
module sram_cmd_q #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_we,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [ADDR_W-1:0]            rsp_addr,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         init_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned WORDS = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [ENT_W-1:0]    fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]   mem [WORDS];

    logic                head_we;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_wdata;
    logic                push, pop, issue_wr, issue_rd;

    assign head_we    = fifo_q[rd_ptr_q][ENT_W-1];
    assign head_addr  = fifo_q[rd_ptr_q][ENT_W-2 -: ADDR_W];
    assign head_wdata = fifo_q[rd_ptr_q][DATA_W-1:0];

    assign init_done = (state_q == RUN);
    assign cmd_ready = (state_q == RUN) && (level < LVL_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = issue_wr || issue_rd;

    // Next state and head issue decision; a blocked read stalls everything behind it.
    always_comb begin
        state_d  = state_q;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q == '1) state_d = RUN;
            end
            RUN: begin
                if (level != '0) begin
                    if (head_we)                       issue_wr = 1'b1;
                    else if (!rsp_valid || rsp_ready)  issue_rd = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= (state_q == INIT) ? init_cnt_q + ADDR_W'(1) : '0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
    end

    // Memory array has no reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) mem[init_cnt_q] <= '0;
        else if (issue_wr)   mem[head_addr]  <= head_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else if (issue_rd) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem[head_addr];
            rsp_addr  <= head_addr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_cmd_q.sv
// Directed bench for sram_cmd_q: default instance plus a wider parameter instance.
module tb_sram_cmd_q;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_addr;
    logic [2:0] level;
    logic       init_done;

    logic        rst2_n;
    logic        cmd_valid2, cmd_ready2, cmd_we2;
    logic [5:0]  cmd_addr2;
    logic [15:0] cmd_wdata2;
    logic        rsp_valid2, rsp_ready2;
    logic [15:0] rsp_data2;
    logic [5:0]  rsp_addr2;
    logic [3:0]  level2;
    logic        init_done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_cmd_q u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .level(level), .init_done(init_done)
    );

    sram_cmd_q #(.DATA_W(16), .ADDR_W(6), .DEPTH(8)) u_dut2 (
        .clk(clk), .rst_n(rst2_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_we(cmd_we2),
        .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_addr(rsp_addr2),
        .level(level2), .init_done(init_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command; it is accepted on the next edge.
    task automatic push(input logic we, input logic [3:0] addr, input logic [7:0] wdata);
        int n;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        rst2_n = 1'b0; cmd_valid2 = 1'b0; cmd_we2 = 1'b0; cmd_addr2 = '0; cmd_wdata2 = '0; rsp_ready2 = 1'b1;

        // reset values
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        #4;
        tick();
        rst_n = 1'b1;
        wait_init("init_edges");

        // read of a cleared word after init, with latency check
        rsp_ready = 1'b1;
        push(1'b0, 4'd9, 8'd0);
        chk("init_rd_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("init_rd_valid", 32'(rsp_valid), 32'd1);
        chk("init_rd_data", 32'(rsp_data), 32'd0);
        chk("init_rd_addr", 32'(rsp_addr), 32'd9);
        tick();
        chk("init_rd_clear", 32'(rsp_valid), 32'd0);

        // basic ordered writes and reads
        push(1'b1, 4'd3, 8'd55);
        push(1'b1, 4'd5, 8'd77);
        push(1'b0, 4'd3, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        chk("basic_r3_valid", 32'(rsp_valid), 32'd1);
        chk("basic_r3_data", 32'(rsp_data), 32'd55);
        chk("basic_r3_addr", 32'(rsp_addr), 32'd3);
        tick();
        chk("basic_r5_data", 32'(rsp_data), 32'd77);
        chk("basic_r5_addr", 32'(rsp_addr), 32'd5);
        chk("basic_level0", 32'(level), 32'd0);
        tick();
        chk("basic_clear", 32'(rsp_valid), 32'd0);

        // backpressure: blocked read stalls the younger write
        rsp_ready = 1'b0;
        push(1'b1, 4'd3, 8'd55);
        push(1'b0, 4'd3, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        push(1'b1, 4'd3, 8'd99);
        tick();
        tick();
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_data", 32'(rsp_data), 32'd55);
        chk("bp_hold_addr", 32'(rsp_addr), 32'd3);
        chk("bp_level", 32'(level), 32'd2);
        rsp_ready = 1'b1;
        tick();
        chk("bp_r5_data", 32'(rsp_data), 32'd77);
        chk("bp_r5_addr", 32'(rsp_addr), 32'd5);
        chk("bp_level1", 32'(level), 32'd1);
        tick();
        chk("bp_wr_level", 32'(level), 32'd0);
        chk("bp_clear", 32'(rsp_valid), 32'd0);
        push(1'b0, 4'd3, 8'd0);
        tick();
        chk("bp_r3_new", 32'(rsp_data), 32'd99);
        tick();

        // full FIFO, no pop-through, drain order
        rsp_ready = 1'b0;
        push(1'b0, 4'd3, 8'd0);
        tick();
        chk("full_slot", 32'(rsp_valid), 32'd1);
        push(1'b0, 4'd5, 8'd0);
        push(1'b0, 4'd3, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        push(1'b0, 4'd3, 8'd0);
        chk("full_level", 32'(level), 32'd4);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd7;
        chk("full_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("full_no_accept", 32'(level), 32'd4);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_level", 32'(level), 32'(3 - i));
            chk("drain_data", 32'(rsp_data), (i % 2 == 0) ? 32'd77 : 32'd99);
        end
        tick();

        // asynchronous reset mid-operation
        rsp_ready = 1'b0;
        push(1'b0, 4'd3, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        push(1'b0, 4'd5, 8'd0);
        chk("mid_level3", 32'(level), 32'd3);
        chk("mid_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        #2 rst_n = 1'b1;
        wait_init("reinit_edges");
        rsp_ready = 1'b1;
        push(1'b0, 4'd3, 8'd0);
        tick();
        chk("reinit_r3_valid", 32'(rsp_valid), 32'd1);
        chk("reinit_r3_data", 32'(rsp_data), 32'd0);
        tick();

        // wider parameter instance
        rst2_n = 1'b1;
        n = 0;
        while (!init_done2 && n < 300) begin
            tick();
            n++;
        end
        chk("p2_init_edges", 32'(n), 32'd64);
        cmd_valid2 = 1'b1; cmd_we2 = 1'b1; cmd_addr2 = 6'd63; cmd_wdata2 = 16'hBEEF;
        chk("p2_ready", 32'(cmd_ready2), 32'd1);
        tick();
        cmd_we2 = 1'b0; cmd_wdata2 = '0;
        tick();
        cmd_valid2 = 1'b0;
        tick();
        chk("p2_valid", 32'(rsp_valid2), 32'd1);
        chk("p2_data", 32'(rsp_data2), 32'hBEEF);
        chk("p2_addr", 32'(rsp_addr2), 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
